// File: rtl/register_file_nw_multi_port_read_ff_if.sv
// Port bundle for the multi-port flip-flop register file.
// The master drives read and write requests. The slave (the register file) returns read data and valid bits.
interface register_file_nw_multi_port_read_ff_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_READ     = 2,
    parameter int N_WRITE    = 2,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [N_READ-1:0]             ReadEnable;
    logic [N_READ*ADDR_WIDTH-1:0]  ReadAddr;
    logic [N_READ*DATA_WIDTH-1:0]  ReadData;
    logic [N_READ-1:0]             ReadValid;

    logic [N_WRITE-1:0]            WriteEnable;
    logic [N_WRITE*ADDR_WIDTH-1:0] WriteAddr;
    logic [N_WRITE*BE_WIDTH-1:0]   WriteBE;
    logic [N_WRITE*DATA_WIDTH-1:0] WriteData;

    modport master (
        output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteBE, WriteData,
        input  ReadData, ReadValid
    );

    modport slave (
        input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteBE, WriteData,
        output ReadData, ReadValid
    );
endinterface

// File: rtl/register_file_nw_multi_port_read_ff.sv
// Flip-flop register file with N_WRITE byte-enabled write ports, N_READ read ports, per-entry valid bits and flush.
// Write ports with a higher index win. READ_MODE selects between address-follows-array and snapshot-with-bypass reads.
module register_file_nw_multi_port_read_ff #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_READ     = 2,
    parameter int N_WRITE    = 2,
    parameter int READ_MODE  = 0,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic test_en_i,
    input  logic flush_i,
    register_file_nw_multi_port_read_ff_if.slave bus,
    output logic collision_o
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

    logic unused_test_en;
    assign unused_test_en = test_en_i;

    logic [ADDR_WIDTH-1:0] raddr_in [N_READ];
    logic [ADDR_WIDTH-1:0] waddr    [N_WRITE];
    logic [BE_WIDTH-1:0]   wbe      [N_WRITE];
    logic [DATA_WIDTH-1:0] wdata    [N_WRITE];

    for (genvar z = 0; z < N_READ; z++) begin : g_rd_unpack
        assign raddr_in[z] = bus.ReadAddr[z*ADDR_WIDTH +: ADDR_WIDTH];
    end

    for (genvar p = 0; p < N_WRITE; p++) begin : g_wr_unpack
        assign waddr[p] = bus.WriteAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign wbe[p]   = bus.WriteBE[p*BE_WIDTH +: BE_WIDTH];
        assign wdata[p] = bus.WriteData[p*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]  valid_q;
    logic [NUM_WORDS-1:0]  valid_d;
    logic                  collision_q;
    logic                  collision_d;

    // Ports are applied in ascending order, so a later (higher) port overwrites the bytes it enables.
    // An enabled port marks its entry valid even with all byte enables low.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        for (int p = 0; p < N_WRITE; p++) begin
            if (bus.WriteEnable[p]) begin
                valid_d[waddr[p]] = 1'b1;
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (wbe[p][b]) begin
                        mem_d[waddr[p]][8*b +: 8] = wdata[p][8*b +: 8];
                    end
                end
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_comb begin
        collision_d = 1'b0;
        for (int p = 0; p < N_WRITE; p++) begin
            for (int q = p + 1; q < N_WRITE; q++) begin
                if (bus.WriteEnable[p] && bus.WriteEnable[q] && (waddr[p] == waddr[q])) begin
                    collision_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
            valid_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            valid_q     <= valid_d;
            collision_q <= collision_d;
        end
    end

    assign collision_o = collision_q;

    if (READ_MODE == 0) begin : g_mode_addr
        for (genvar z = 0; z < N_READ; z++) begin : g_port
            logic [ADDR_WIDTH-1:0] raddr_q;
            logic [ADDR_WIDTH-1:0] raddr_d;

            assign raddr_d = bus.ReadEnable[z] ? raddr_in[z] : raddr_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    raddr_q <= '0;
                end else begin
                    raddr_q <= raddr_d;
                end
            end

            assign bus.ReadData[z*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_q];
            assign bus.ReadValid[z]                         = valid_q[raddr_q];
        end
    end else begin : g_mode_snap
        for (genvar z = 0; z < N_READ; z++) begin : g_port
            logic [DATA_WIDTH-1:0] rdata_q;
            logic [DATA_WIDTH-1:0] rdata_d;
            logic                  rvalid_q;
            logic                  rvalid_d;

            // Sampling the next-state array bypasses same-cycle writes and flush into the snapshot.
            assign rdata_d  = bus.ReadEnable[z] ? mem_d[raddr_in[z]]   : rdata_q;
            assign rvalid_d = bus.ReadEnable[z] ? valid_d[raddr_in[z]] : rvalid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign bus.ReadData[z*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
            assign bus.ReadValid[z]                         = rvalid_q;
        end
    end

endmodule

// File: tb/tb_register_file_nw_multi_port_read_ff.sv
// Scoreboard bench for the multi-port register file: one DUT per read mode, both driven with identical stimulus.
// Directed cases carry hand-computed expectations, and a reference model covers every cycle.
module tb_register_file_nw_multi_port_read_ff;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int BW = DW / 8;
    localparam int NWORDS = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test_en = 1'b0;
    logic flush = 1'b0;
    logic coll0, coll1;

    always #5 clk = ~clk;

    register_file_nw_multi_port_read_ff_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW)) bus0 ();
    register_file_nw_multi_port_read_ff_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW)) bus1 ();

    register_file_nw_multi_port_read_ff #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW), .READ_MODE(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .flush_i(flush),
        .bus(bus0.slave), .collision_o(coll0)
    );

    register_file_nw_multi_port_read_ff #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW), .READ_MODE(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .flush_i(flush),
        .bus(bus1.slave), .collision_o(coll1)
    );

    typedef struct {
        logic [NR*DW-1:0] d0;
        logic [NR-1:0]    v0;
        logic [NR*DW-1:0] d1;
        logic [NR-1:0]    v1;
        logic             coll;
        logic             h_m0;
        logic             h_m1;
        int               h_port;
        logic [DW-1:0]    h_data;
        logic             h_v;
        logic             h_coll_en;
        logic             h_coll;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    // Stimulus variables
    logic [NR-1:0] re;
    logic [AW-1:0] ra [NR];
    logic [NW-1:0] we;
    logic [AW-1:0] wa [NW];
    logic [BW-1:0] be [NW];
    logic [DW-1:0] wd [NW];
    logic          fl;

    // Hand-computed expectations attached to the next step
    logic          h_m0, h_m1, h_v, h_coll_en, h_coll;
    int            h_port;
    logic [DW-1:0] h_data;

    // Reference model
    logic [DW-1:0] m_mem [NWORDS];
    logic          m_val [NWORDS];
    logic [AW-1:0] m_raddr [NR];
    logic [DW-1:0] m_sd [NR];
    logic          m_sv [NR];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic clear_hand();
        h_m0 = 1'b0; h_m1 = 1'b0; h_v = 1'b0; h_coll_en = 1'b0; h_coll = 1'b0;
        h_port = 0; h_data = '0;
    endtask

    task automatic idle_stim();
        re = '0; we = '0; fl = 1'b0;
        for (int z = 0; z < NR; z++) ra[z] = '0;
        for (int p = 0; p < NW; p++) begin
            wa[p] = '0; be[p] = '0; wd[p] = '0;
        end
    endtask

    task automatic apply();
        logic [NR*AW-1:0] rav;
        logic [NW*AW-1:0] wav;
        logic [NW*BW-1:0] bev;
        logic [NW*DW-1:0] wdv;
        for (int z = 0; z < NR; z++) rav[z*AW +: AW] = ra[z];
        for (int p = 0; p < NW; p++) begin
            wav[p*AW +: AW] = wa[p];
            bev[p*BW +: BW] = be[p];
            wdv[p*DW +: DW] = wd[p];
        end
        bus0.ReadEnable = re;  bus1.ReadEnable = re;
        bus0.ReadAddr = rav;   bus1.ReadAddr = rav;
        bus0.WriteEnable = we; bus1.WriteEnable = we;
        bus0.WriteAddr = wav;  bus1.WriteAddr = wav;
        bus0.WriteBE = bev;    bus1.WriteBE = bev;
        bus0.WriteData = wdv;  bus1.WriteData = wdv;
        flush = fl;
    endtask

    task automatic model_reset();
        for (int w = 0; w < NWORDS; w++) begin
            m_mem[w] = '0; m_val[w] = 1'b0;
        end
        for (int z = 0; z < NR; z++) begin
            m_raddr[z] = '0; m_sd[z] = '0; m_sv[z] = 1'b0;
        end
    endtask

    // Drive one cycle's stimulus and queue the state expected just after the following edge
    task automatic step();
        exp_t e;
        logic [DW-1:0] mn [NWORDS];
        logic          vn [NWORDS];
        logic          c;
        @(negedge clk);
        apply();
        mn = m_mem;
        vn = m_val;
        for (int p = 0; p < NW; p++) begin
            if (we[p]) begin
                vn[wa[p]] = 1'b1;
                for (int b = 0; b < BW; b++)
                    if (be[p][b]) mn[wa[p]][8*b +: 8] = wd[p][8*b +: 8];
            end
        end
        if (fl) for (int w = 0; w < NWORDS; w++) vn[w] = 1'b0;
        c = 1'b0;
        for (int p = 0; p < NW; p++)
            for (int q = p + 1; q < NW; q++)
                if (we[p] && we[q] && wa[p] == wa[q]) c = 1'b1;
        for (int z = 0; z < NR; z++) begin
            if (re[z]) begin
                m_raddr[z] = ra[z];
                m_sd[z] = mn[ra[z]];
                m_sv[z] = vn[ra[z]];
            end
        end
        m_mem = mn;
        m_val = vn;
        for (int z = 0; z < NR; z++) begin
            e.d0[z*DW +: DW] = mn[m_raddr[z]];
            e.v0[z]          = vn[m_raddr[z]];
            e.d1[z*DW +: DW] = m_sd[z];
            e.v1[z]          = m_sv[z];
        end
        e.coll = c;
        e.h_m0 = h_m0; e.h_m1 = h_m1; e.h_port = h_port; e.h_data = h_data;
        e.h_v = h_v; e.h_coll_en = h_coll_en; e.h_coll = h_coll;
        sb.push_back(e);
        clear_hand();
    endtask

    task automatic check_all_zero(input string tag);
        for (int z = 0; z < NR; z++) begin
            chk({tag, "_m0_rdata"}, bus0.ReadData[z*DW +: DW], '0);
            chk({tag, "_m0_rvalid"}, DW'(bus0.ReadValid[z]), '0);
            chk({tag, "_m1_rdata"}, bus1.ReadData[z*DW +: DW], '0);
            chk({tag, "_m1_rvalid"}, DW'(bus1.ReadValid[z]), '0);
        end
        chk({tag, "_m0_coll"}, DW'(coll0), '0);
        chk({tag, "_m1_coll"}, DW'(coll1), '0);
    endtask

    // Monitor: every cycle is an output cycle for this block, so pop one expectation per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int z = 0; z < NR; z++) begin
                    chk($sformatf("m0_rdata%0d", z), bus0.ReadData[z*DW +: DW], e.d0[z*DW +: DW]);
                    chk($sformatf("m0_rvalid%0d", z), DW'(bus0.ReadValid[z]), DW'(e.v0[z]));
                    chk($sformatf("m1_rdata%0d", z), bus1.ReadData[z*DW +: DW], e.d1[z*DW +: DW]);
                    chk($sformatf("m1_rvalid%0d", z), DW'(bus1.ReadValid[z]), DW'(e.v1[z]));
                end
                chk("m0_collision", DW'(coll0), DW'(e.coll));
                chk("m1_collision", DW'(coll1), DW'(e.coll));
                if (e.h_m0) begin
                    chk("hand_m0_rdata", bus0.ReadData[e.h_port*DW +: DW], e.h_data);
                    chk("hand_m0_rvalid", DW'(bus0.ReadValid[e.h_port]), DW'(e.h_v));
                end
                if (e.h_m1) begin
                    chk("hand_m1_rdata", bus1.ReadData[e.h_port*DW +: DW], e.h_data);
                    chk("hand_m1_rvalid", DW'(bus1.ReadValid[e.h_port]), DW'(e.h_v));
                end
                if (e.h_coll_en) chk("hand_collision", DW'(coll0), DW'(e.h_coll));
            end
        end
    end

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            re = NR'($urandom);
            for (int z = 0; z < NR; z++) ra[z] = AW'($urandom_range(0, 7));
            we = NW'($urandom);
            for (int p = 0; p < NW; p++) begin
                wa[p] = AW'($urandom_range(0, 7));
                be[p] = BW'($urandom);
                wd[p] = $urandom;
            end
            fl = ($urandom_range(0, 15) == 0);
            step();
        end
    endtask

    initial begin
        clear_hand();
        idle_stim();
        apply();
        model_reset();
        #3;
        check_all_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Two-port byte merge on word 3 with collision
        idle_stim();
        we = 2'b11;
        wa[0] = 5'd3; be[0] = 4'b1111; wd[0] = 32'h1111_1111;
        wa[1] = 5'd3; be[1] = 4'b0011; wd[1] = 32'h2222_AAAA;
        re = 2'b01; ra[0] = 5'd3;
        h_m0 = 1'b1; h_m1 = 1'b1; h_port = 0; h_data = 32'h1111_AAAA; h_v = 1'b1;
        h_coll_en = 1'b1; h_coll = 1'b1;
        step();

        // Read-after-write bypass on word 5
        idle_stim();
        we = 2'b01; wa[0] = 5'd5; be[0] = 4'b1111; wd[0] = 32'hDEAD_BEEF;
        re = 2'b01; ra[0] = 5'd5;
        h_m0 = 1'b1; h_m1 = 1'b1; h_port = 0; h_data = 32'hDEAD_BEEF; h_v = 1'b1;
        h_coll_en = 1'b1; h_coll = 1'b0;
        step();

        // Mode 0 address tracking on read port 1
        idle_stim();
        re = 2'b10; ra[1] = 5'd7;
        step();
        idle_stim();
        we = 2'b01; wa[0] = 5'd7; be[0] = 4'b1111; wd[0] = 32'h0000_1234;
        h_m0 = 1'b1; h_port = 1; h_data = 32'h0000_1234; h_v = 1'b1;
        step();

        // Flush beats a same-cycle write for valid, data still lands
        idle_stim();
        fl = 1'b1;
        we = 2'b10; wa[1] = 5'd2; be[1] = 4'b1111; wd[1] = 32'h0000_0055;
        re = 2'b11; ra[0] = 5'd2; ra[1] = 5'd2;
        h_m0 = 1'b1; h_m1 = 1'b1; h_port = 0; h_data = 32'h0000_0055; h_v = 1'b0;
        step();

        // Enabled write with no byte enables still sets valid
        idle_stim();
        we = 2'b01; wa[0] = 5'd9; be[0] = 4'b0000; wd[0] = 32'hFFFF_FFFF;
        re = 2'b10; ra[1] = 5'd9;
        h_m0 = 1'b1; h_m1 = 1'b1; h_port = 1; h_data = 32'h0000_0000; h_v = 1'b1;
        step();

        rand_steps(300);

        // Asynchronous reset in the middle of active traffic
        @(negedge clk);
        re = '1; we = '1; fl = 1'b0;
        for (int p = 0; p < NW; p++) begin
            wa[p] = AW'(p + 1); be[p] = '1; wd[p] = 32'hA5A5_0000 + p;
        end
        apply();
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_stim();
        apply();

        rand_steps(200);

        idle_stim();
        step();
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drain", DW'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
